// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller: FSM state encoding,
// bridge register word addresses and the default source count.
package irq_ctrl_pkg;

    localparam int unsigned NUM_SRC = 6;
    localparam int unsigned ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_MASK   = 2'd0;
    localparam logic [1:0] ADDR_PEND   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int unsigned CTRL_MODE_LSB = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request index and whether
// any request is set at all.
module irq_prio_enc #(
    parameter int unsigned WIDTH = irq_ctrl_pkg::NUM_SRC
) (
    input  logic [WIDTH-1:0]              req,
    output logic                          valid,
    output logic [irq_ctrl_pkg::ID_W-1:0] id
);
    import irq_ctrl_pkg::*;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level capture into PEND, MASK/CTRL registers and a
// three-state handshake FSM presenting one source at a time to the CPU.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = irq_ctrl_pkg::NUM_SRC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [1:0]         addr,
    input  logic               we,
    input  logic [31:0]        wd,
    output logic [31:0]        rd,
    input  logic               int_ack,
    input  logic               int_done,
    output logic [NUM_SRC-1:0] hwint
);
    import irq_ctrl_pkg::*;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [NUM_SRC-1:0] irq_q, irq_qd;
    logic [NUM_SRC-1:0] mask_q, pend_q, pend_d, mode_q;
    logic               en_q;

    logic [NUM_SRC-1:0] rise, pend_set, pend_wclr, ack_clr, cur_oh;
    logic               cur_live, cur_valid;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_id;
    logic               unused_wd;

    assign unused_wd = ^wd;

    irq_prio_enc #(
        .WIDTH (NUM_SRC)
    ) u_prio_enc (
        .req   (pend_q & mask_q),
        .valid (enc_valid),
        .id    (enc_id)
    );

    assign rise      = irq_q & ~irq_qd;
    assign pend_set  = (rise & mode_q) | (irq_q & ~mode_q);
    assign pend_wclr = (we && addr == ADDR_PEND) ? wd[NUM_SRC-1:0] : '0;
    assign cur_oh    = {{(NUM_SRC-1){1'b0}}, 1'b1} << cur_id_q;
    assign cur_live  = en_q && |(pend_q & mask_q & cur_oh);
    assign cur_valid = (state_q != IDLE);
    assign hwint     = (state_q == ASSERT) ? cur_oh : '0;

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        ack_clr  = '0;
        unique case (state_q)
            IDLE: begin
                if (en_q && enc_valid) begin
                    state_d  = ASSERT;
                    cur_id_d = enc_id;
                end
            end
            ASSERT: begin
                // Acknowledge takes priority over any withdraw condition.
                if (int_ack) begin
                    state_d = SERVICE;
                    ack_clr = cur_oh & mode_q;
                end else if (!cur_live) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (int_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // New set events win over same-cycle clears.
        pend_d = (pend_q & ~(pend_wclr | ack_clr)) | pend_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cur_id_q <= '0;
            irq_q    <= '0;
            irq_qd   <= '0;
            mask_q   <= '0;
            pend_q   <= '0;
            mode_q   <= '0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            irq_q    <= irq_in;
            irq_qd   <= irq_q;
            pend_q   <= pend_d;
            if (we && addr == ADDR_MASK) begin
                mask_q <= wd[NUM_SRC-1:0];
            end
            if (we && addr == ADDR_CTRL) begin
                en_q   <= wd[0];
                mode_q <= wd[CTRL_MODE_LSB +: NUM_SRC];
            end
        end
    end

    always_comb begin
        rd = '0;
        unique case (addr)
            ADDR_MASK: rd[NUM_SRC-1:0] = mask_q;
            ADDR_PEND: rd[NUM_SRC-1:0] = pend_q;
            ADDR_STATUS: begin
                rd[9:8]      = state_q;
                rd[4]        = cur_valid;
                rd[ID_W-1:0] = cur_id_q;
            end
            ADDR_CTRL: begin
                rd[0]                        = en_q;
                rd[CTRL_MODE_LSB +: NUM_SRC] = mode_q;
            end
        endcase
    end

endmodule
